// File: rtl/catch_manager_pkg.sv
// Shared game definitions: FSM state encoding and the default score ceiling.
// Used by the collectible, player, display and catch-manager blocks so every
// stage agrees on the same state encodings and score range.
package catch_manager_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CARRY   = 2'd1,
    ST_DELIVER = 2'd2
  } game_state_t;

  localparam logic [9:0] SCORE_MAX_DEF = 10'd999;

endpackage

// File: rtl/catch_manager_rect_overlap.sv
// rect_overlap: combinational axis-aligned rectangle intersection test.
// Rectangles are given as top-left corner plus size. Edge sums are formed in
// 11 bits so a rectangle reaching past coordinate 1023 does not wrap.
// Touching edges (strict less-than fails) do not count as overlap.
//   ax, ay, aw, ah : rectangle A (10 bits each)
//   bx, by, bw, bh : rectangle B (10 bits each)
//   hit            : 1 when the rectangles intersect
module rect_overlap (
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] aw,
  input  logic [9:0] ah,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic [9:0] bw,
  input  logic [9:0] bh,
  output logic       hit
);

  logic [10:0] a_right;
  logic [10:0] a_bottom;
  logic [10:0] b_right;
  logic [10:0] b_bottom;

  assign a_right  = {1'b0, ax} + {1'b0, aw};
  assign a_bottom = {1'b0, ay} + {1'b0, ah};
  assign b_right  = {1'b0, bx} + {1'b0, bw};
  assign b_bottom = {1'b0, by} + {1'b0, bh};

  assign hit = ({1'b0, bx} < a_right)  && ({1'b0, ax} < b_right) &&
               ({1'b0, by} < a_bottom) && ({1'b0, ay} < b_bottom);

endmodule

// File: rtl/catch_manager.sv
// catch_manager: tracks boxes caught by the player, banks them into the score
// after the player lingers in the drop zone, and throttles box spawning.
//   clk, rst (async, active-low)
//   game_en                : advance enable, everything holds when low
//   player_x/y/w/h         : player rectangle
//   box_x/y/w/h            : collectible rectangle
//   box_active             : collectible in flight
//   box_caught             : one-cycle catch pulse
//   player_is_holding_box  : spawn inhibit (full hands or delivering)
//   carry_count            : boxes held
//   score                  : banked total, saturating at SCORE_MAX
//   deliver_pulse          : one-cycle pulse on completed delivery
module catch_manager
  import catch_manager_pkg::*;
#(
  parameter logic [2:0] MAX_CARRY      = 3'd3,
  parameter logic [9:0] DROP_X_MAX     = 10'd80,
  parameter logic [7:0] DELIVER_CYCLES = 8'd30,
  parameter logic [9:0] SCORE_MAX      = SCORE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [9:0] player_w,
  input  logic [9:0] player_h,
  input  logic [9:0] box_x,
  input  logic [9:0] box_y,
  input  logic [9:0] box_w,
  input  logic [9:0] box_h,
  input  logic       box_active,
  output logic       box_caught,
  output logic       player_is_holding_box,
  output logic [2:0] carry_count,
  output logic [9:0] score,
  output logic       deliver_pulse
);

  game_state_t state;
  logic        overlap;
  logic        overlap_q;
  logic        catch_lock;
  logic [7:0]  dcnt;
  logic        in_zone;
  logic        catch_now;

  function automatic logic [9:0] sat_add(input logic [9:0] s, input logic [2:0] c);
    logic [10:0] sum;
    sum = {1'b0, s} + {8'd0, c};
    if (sum > {1'b0, SCORE_MAX}) return SCORE_MAX;
    return sum[9:0];
  endfunction

  rect_overlap u_overlap (
    .ax (player_x),
    .ay (player_y),
    .aw (player_w),
    .ah (player_h),
    .bx (box_x),
    .by (box_y),
    .bw (box_w),
    .bh (box_h),
    .hit(overlap)
  );

  assign in_zone = (player_x <= DROP_X_MAX);

  // Uses the registered overlap, so a catch lands one cycle after the
  // intersection is first seen and box_caught appears one cycle after that.
  assign catch_now = game_en && box_active && overlap_q && !catch_lock &&
                     (carry_count < MAX_CARRY) && (state != ST_DELIVER);

  assign player_is_holding_box = (carry_count == MAX_CARRY) || (state == ST_DELIVER);

  // Stage boundary: overlap_q, catch/delivery control and score register here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      overlap_q     <= 1'b0;
      catch_lock    <= 1'b0;
      box_caught    <= 1'b0;
      deliver_pulse <= 1'b0;
      carry_count   <= 3'd0;
      dcnt          <= 8'd0;
      score         <= 10'd0;
    end else begin
      box_caught    <= catch_now;
      deliver_pulse <= 1'b0;
      if (game_en) begin
        overlap_q <= overlap;
        // One catch per flight: the lock is only released once the box is gone.
        if (catch_now)        catch_lock <= 1'b1;
        else if (!box_active) catch_lock <= 1'b0;

        case (state)
          ST_IDLE: begin
            if (catch_now) begin
              carry_count <= carry_count + 3'd1;
              state       <= ST_CARRY;
            end
          end
          ST_CARRY: begin
            // A catch on the zone-entry cycle still counts toward this delivery.
            if (catch_now) carry_count <= carry_count + 3'd1;
            if (in_zone) begin
              state <= ST_DELIVER;
              dcnt  <= 8'd0;
            end
          end
          ST_DELIVER: begin
            if (!in_zone) begin
              state <= ST_CARRY;
              dcnt  <= 8'd0;
            end else if (dcnt == DELIVER_CYCLES - 8'd1) begin
              score         <= sat_add(score, carry_count);
              carry_count   <= 3'd0;
              deliver_pulse <= 1'b1;
              state         <= ST_IDLE;
              dcnt          <= 8'd0;
            end else begin
              dcnt <= dcnt + 8'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_catch_manager.sv
// Directed bench for catch_manager with default parameters.
module tb_catch_manager;

  logic       clk;
  logic       rst;
  logic       game_en;
  logic [9:0] player_x, player_y, player_w, player_h;
  logic [9:0] box_x, box_y, box_w, box_h;
  logic       box_active;
  logic       box_caught;
  logic       player_is_holding_box;
  logic [2:0] carry_count;
  logic [9:0] score;
  logic       deliver_pulse;

  int n_cmp;
  int n_err;
  int pc, pd;

  catch_manager dut (
    .clk                  (clk),
    .rst                  (rst),
    .game_en              (game_en),
    .player_x             (player_x),
    .player_y             (player_y),
    .player_w             (player_w),
    .player_h             (player_h),
    .box_x                (box_x),
    .box_y                (box_y),
    .box_w                (box_w),
    .box_h                (box_h),
    .box_active           (box_active),
    .box_caught           (box_caught),
    .player_is_holding_box(player_is_holding_box),
    .carry_count          (carry_count),
    .score                (score),
    .deliver_pulse        (deliver_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int caught_cnt, output int deliv_cnt);
    caught_cnt = 0;
    deliv_cnt  = 0;
    repeat (n) begin
      tick();
      if (box_caught)    caught_cnt++;
      if (deliver_pulse) deliv_cnt++;
    end
  endtask

  // One full flight ending in a catch; player assumed at (290,210,40,40).
  task automatic catch_one();
    box_active = 1'b0; box_x = 10'd600; tick();
    box_x = 10'd300; box_y = 10'd200; box_active = 1'b1; tick(); tick();
    box_active = 1'b0; box_x = 10'd600; tick();
  endtask

  // From CARRY: one entry cycle plus DELIVER_CYCLES cycles in the zone.
  task automatic deliver();
    player_x = 10'd50;
    repeat (31) tick();
    player_x = 10'd290;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; game_en = 1'b0;
    player_x = 10'd290; player_y = 10'd210; player_w = 10'd40; player_h = 10'd40;
    box_x = 10'd300; box_y = 10'd200; box_w = 10'd30; box_h = 10'd30;
    box_active = 1'b1;
    #1;
    chk("reset_carry", carry_count, 0);
    chk("reset_score", score, 0);
    chk("reset_caught", box_caught, 0);
    chk("reset_deliver", deliver_pulse, 0);
    chk("reset_holding", player_is_holding_box, 0);
    repeat (2) tick();
    rst = 1'b1;

    // Overlapping and active, but game_en low: nothing may advance.
    run(5, pc, pd);
    chk("hold_no_catch", pc, 0);
    chk("hold_carry", carry_count, 0);

    // Overlap begins now: pulse on the second edge.
    game_en = 1'b1;
    tick();
    chk("catch_lat1", box_caught, 0);
    tick();
    chk("catch_lat2", box_caught, 1);
    chk("catch_carry1", carry_count, 1);

    // Same flight, overlap held 50 cycles: no further catch.
    run(50, pc, pd);
    chk("one_per_flight", pc, 0);
    chk("carry_still1", carry_count, 1);

    // New flight (box_active drops for one cycle): second catch allowed.
    box_active = 1'b0; tick();
    box_active = 1'b1;
    run(5, pc, pd);
    chk("second_flight", pc, 1);
    chk("carry2", carry_count, 2);
    box_active = 1'b0; box_x = 10'd600; tick();

    // Delivery aborted after 15 cycles in the zone.
    player_x = 10'd50; tick();
    chk("deliver_holding", player_is_holding_box, 1);
    run(14, pc, pd);
    chk("abort_no_pulse", pd, 0);
    player_x = 10'd290; tick();
    chk("abort_back_carry", player_is_holding_box, 0);
    chk("abort_keeps_carry", carry_count, 2);

    // Re-entry restarts the count: pulse only on the 30th DELIVER cycle.
    player_x = 10'd50;
    run(30, pc, pd);
    chk("reentry_no_early", pd, 0);
    chk("reentry_score0", score, 0);
    tick();
    chk("deliver_pulse", deliver_pulse, 1);
    chk("deliver_score2", score, 2);
    chk("deliver_carry0", carry_count, 0);
    player_x = 10'd290; tick();
    chk("deliver_pulse_1cyc", deliver_pulse, 0);

    // In the zone with nothing held: no delivery.
    player_x = 10'd50;
    run(40, pc, pd);
    chk("empty_zone_pulse", pd, 0);
    chk("empty_zone_holding", player_is_holding_box, 0);
    chk("empty_zone_score", score, 2);
    player_x = 10'd290; tick();

    // Catch on the same cycle as zone entry is taken; none during DELIVER.
    catch_one();
    box_x = 10'd90; box_active = 1'b1; player_x = 10'd81;
    tick();
    chk("edge_catch_pre", box_caught, 0);
    player_x = 10'd80;
    tick();
    chk("edge_catch", box_caught, 1);
    chk("edge_carry2", carry_count, 2);
    chk("edge_holding", player_is_holding_box, 1);
    box_active = 1'b0; tick();
    box_active = 1'b1;
    run(28, pc, pd);
    chk("no_catch_in_deliver", pc, 0);
    chk("no_early_pulse2", pd, 0);
    box_active = 1'b0;
    tick();
    chk("edge_deliver_pulse", deliver_pulse, 1);
    chk("edge_score4", score, 4);
    box_x = 10'd600; player_x = 10'd290; tick();

    // Full hands: no catch, spawn inhibited.
    catch_one(); catch_one(); catch_one();
    chk("full_carry3", carry_count, 3);
    chk("full_holding", player_is_holding_box, 1);
    box_x = 10'd300; box_active = 1'b1;
    run(10, pc, pd);
    chk("full_no_catch", pc, 0);
    chk("full_carry_stays", carry_count, 3);
    box_active = 1'b0; box_x = 10'd600; tick();
    deliver();
    chk("score7", score, 7);

    // Climb to 998 (7 + 330*3 + 1), then saturate.
    for (int i = 0; i < 330; i++) begin
      catch_one(); catch_one(); catch_one();
      deliver();
    end
    catch_one();
    deliver();
    chk("score998", score, 998);
    catch_one(); catch_one(); catch_one();
    deliver();
    chk("score_sat999", score, 999);

    // Reset mid-delivery discards the held boxes.
    rst = 1'b0; #1; rst = 1'b1;
    tick();
    catch_one(); catch_one(); catch_one();
    player_x = 10'd50; tick();
    run(10, pc, pd);
    rst = 1'b0; #1;
    chk("midrst_carry", carry_count, 0);
    chk("midrst_score", score, 0);
    chk("midrst_holding", player_is_holding_box, 0);
    chk("midrst_caught", box_caught, 0);
    chk("midrst_pulse", deliver_pulse, 0);
    rst = 1'b1;
    run(40, pc, pd);
    chk("postrst_no_pulse", pd, 0);
    chk("postrst_score", score, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
